data_sram_slave: RTL

Responder end of the data-side SRAM-like bus: accepts load/store requests from the CPU's EXE stage and returns `data_ok`/`rdata` to the MEM stage, backed by an internal word-addressed RAM. Responses come back in order after a fixed, parameterised latency, with a bounded number of outstanding requests. The block is the standard memory model for pipeline bring-up and the reference slave for later AXI-bridge verification.

---
 rtl/data_sram_if.sv | 22 ++
 rtl/data_sram_slave.sv | 85 ++++++++
 2 files changed

// File: rtl/data_sram_if.sv
// rtl/data_sram_if.sv - Data-side SRAM-like bus between CPU pipeline and memory responder
interface data_sram_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/data_sram_slave.sv
// rtl/data_sram_slave.sv - Word-addressed RAM responder with fixed-latency, in-order response queue
module data_sram_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 2
) (
  input  logic       clk,
  input  logic       reset,
  data_sram_if.slave bus
);

  localparam int         WORDS    = 1 << ADDR_WIDTH;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);
  localparam logic [1:0] LAST_IDX = 2'(DEPTH - 1);
  localparam logic [2:0] FULL_CNT = 3'(DEPTH);

  logic [31:0]           mem [WORDS];
  // Sized for the largest legal DEPTH so 2-bit pointers index them exactly.
  logic [31:0]           q_rdata [4];
  logic [2:0]            q_cnt   [4];
  logic [3:0]            q_vld;
  logic [1:0]            head;
  logic [1:0]            tail;
  logic [2:0]            count;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  accept;
  logic                  pop;
  logic                  unused_bits;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
  endfunction

  assign idx         = bus.addr[ADDR_WIDTH+1:2];
  assign unused_bits = ^{bus.size, bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

  // Acceptance depends on registered occupancy only, never on this cycle's pop.
  assign bus.addr_ok = (count < FULL_CNT);
  assign accept      = bus.req && bus.addr_ok;
  assign pop         = q_vld[head] && (q_cnt[head] == 3'd0);
  assign bus.data_ok = pop;
  assign bus.rdata   = pop ? q_rdata[head] : 32'd0;

  always_ff @(posedge clk) begin
    if (!reset && accept && bus.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) begin
          mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= 2'd0;
      tail  <= 2'd0;
      count <= 3'd0;
      q_vld <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (q_vld[i] && (q_cnt[i] != 3'd0)) begin
          q_cnt[i] <= q_cnt[i] - 3'd1;
        end
      end
      if (pop) begin
        q_vld[head] <= 1'b0;
        head        <= ptr_next(head);
      end
      // The load snapshot sees every earlier store, since those were written on prior edges.
      if (accept) begin
        q_vld[tail]   <= 1'b1;
        q_cnt[tail]   <= CNT_INIT;
        q_rdata[tail] <= bus.wr ? 32'd0 : mem[idx];
        tail          <= ptr_next(tail);
      end
      case ({accept, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
